// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and constants for the FIFO write-port arbiter: FSM states,
// header word layout and truncation counter width.
package fifo_write_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_BURST  = 2'd2
    } arb_state_t;

    localparam logic [3:0] HDR_MAGIC     = 4'hA;
    localparam int         HDR_W         = 16;
    localparam int         HDR_MAGIC_LSB = 12;
    localparam int         HDR_PORT_LSB  = 8;
    localparam int         TRUNC_W       = 16;

    // Header word announcing which requester owns the packet that follows.
    function automatic logic [HDR_W-1:0] make_header(input logic [3:0] port);
        logic [HDR_W-1:0] h;
        h = '0;
        h[HDR_MAGIC_LSB +: 4] = HDR_MAGIC;
        h[HDR_PORT_LSB  +: 4] = port;
        return h;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester and FIFO write-side bundle of the arbiter. The master modport is the
// requester/FIFO side, the slave modport is the arbiter.
interface fifo_write_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 16,
    parameter int SIZE_WIDTH = 10
);
    import fifo_write_arbiter_pkg::*;

    logic [NUM_PORTS-1:0]            req_valid;
    logic [NUM_PORTS*DATA_WIDTH-1:0] req_data;
    logic [NUM_PORTS-1:0]            req_last;
    logic [NUM_PORTS-1:0]            req_ready;
    logic                            fifo_wr_en;
    logic [DATA_WIDTH-1:0]           fifo_wr_data;
    logic                            fifo_wr_full;
    logic [SIZE_WIDTH-1:0]           fifo_wr_free;
    logic [NUM_PORTS-1:0]            grant;
    logic [TRUNC_W-1:0]              trunc_count;

    modport master (
        output req_valid, req_data, req_last, fifo_wr_full, fifo_wr_free,
        input  req_ready, fifo_wr_en, fifo_wr_data, grant, trunc_count
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_wr_full, fifo_wr_free,
        output req_ready, fifo_wr_en, fifo_wr_data, grant, trunc_count
    );

endinterface

// File: rtl/fifo_write_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first asserted request at or after the
// start index, wrapping; returns one-hot pick, its index and a found flag.
module rr_priority_picker #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     start,
    output logic [NUM_PORTS-1:0] pick,
    output logic [IDX_W-1:0]     pick_idx,
    output logic                 found
);

    int p;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        p        = 0;
        for (int off = 0; off < NUM_PORTS; off++) begin
            p = int'(start) + off;
            if (p >= NUM_PORTS) begin
                p = p - NUM_PORTS;
            end
            if (!found && req[p]) begin
                found    = 1'b1;
                pick[p]  = 1'b1;
                pick_idx = IDX_W'(p);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-locked arbiter sharing one FIFO write port between requesters.
// Optional build macro FIFO_ARB_HEADER_EN inserts a one-word packet header.
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 16,
    parameter int SIZE_WIDTH = 10,
    parameter int MIN_FREE   = 64,
    parameter int MAX_BURST  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    fifo_write_arbiter_if.slave   bus
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [SIZE_WIDTH-1:0] MIN_FREE_W   = SIZE_WIDTH'(MIN_FREE);
    // One word may already sit in the output register, so a burst needs room for two.
    localparam logic [SIZE_WIDTH-1:0] BURST_FREE_W = SIZE_WIDTH'(2);
    localparam logic [CNT_W-1:0]      LIMIT_CNT    = CNT_W'(MAX_BURST - 1);

    arb_state_t             state_q, state_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]       gidx_q, gidx_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic [TRUNC_W-1:0]     trunc_q, trunc_d;

    logic [NUM_PORTS-1:0]   pick;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_found;
    logic                   space_ok;
    logic                   start_ok;
    logic [NUM_PORTS-1:0]   ready;
    logic [DATA_WIDTH-1:0]  g_data;
    logic                   accept;
    logic                   acc_last;
    logic                   acc_limit;

    function automatic logic [TRUNC_W-1:0] sat_inc(input logic [TRUNC_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [IDX_W-1:0] next_port(input logic [IDX_W-1:0] i);
        return (int'(i) == NUM_PORTS - 1) ? '0 : i + 1'b1;
    endfunction

    rr_priority_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req      (bus.req_valid),
        .start    (rr_q),
        .pick     (pick),
        .pick_idx (pick_idx),
        .found    (pick_found)
    );

    always_comb begin
        space_ok  = (bus.fifo_wr_free >= BURST_FREE_W) && !bus.fifo_wr_full;
        start_ok  = pick_found && (bus.fifo_wr_free >= MIN_FREE_W) && !bus.fifo_wr_full;
        ready     = '0;
        if (state_q == ST_BURST && space_ok) begin
            ready = grant_q;
        end
        g_data    = bus.req_data[int'(gidx_q) * DATA_WIDTH +: DATA_WIDTH];
        accept    = |(bus.req_valid & ready);
        acc_last  = accept && bus.req_last[gidx_q];
        acc_limit = accept && !bus.req_last[gidx_q] && (cnt_q == LIMIT_CNT);
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        trunc_d   = trunc_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    grant_d = pick;
                    gidx_d  = pick_idx;
                    cnt_d   = '0;
`ifdef FIFO_ARB_HEADER_EN
                    state_d = ST_HEADER;
`else
                    state_d = ST_BURST;
`endif
                end
            end
`ifdef FIFO_ARB_HEADER_EN
            ST_HEADER: begin
                wr_en_d   = 1'b1;
                wr_data_d = DATA_WIDTH'(make_header(4'(gidx_q)));
                state_d   = ST_BURST;
            end
`endif
            ST_BURST: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = g_data;
                    cnt_d     = cnt_q + 1'b1;
                    // A truncated packet's remainder re-enters arbitration as a new packet.
                    if (acc_last || acc_limit) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        rr_d    = next_port(gidx_q);
                    end
                    if (acc_limit) begin
                        trunc_d = sat_inc(trunc_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output register stage: accepted word reaches the FIFO one cycle after acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            trunc_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            trunc_q   <= trunc_d;
        end
    end

    assign bus.req_ready    = ready;
    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_wr_data = wr_data_q;
    assign bus.grant        = grant_q;
    assign bus.trunc_count  = trunc_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: queued packets per requester are
// compared against a packet-level round-robin model of the FIFO stream.
module tb_fifo_write_arbiter;

    localparam int NP   = 2;
    localparam int DW   = 16;
    localparam int SW   = 10;
    localparam int MINF = 64;
    localparam int MAXB = 256;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fifo_write_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .SIZE_WIDTH(SW)) bus ();

    fifo_write_arbiter #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW),
        .SIZE_WIDTH (SW),
        .MIN_FREE   (MINF),
        .MAX_BURST  (MAXB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Each entry: {last, word}
    logic [DW:0]   pq [NP][$];
    logic [DW:0]   mq [NP][$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] wr_log[$];
    logic [NP-1:0] exp_grants[$];
    logic [NP-1:0] grant_log[$];
    int            model_rr  = 0;
    int            exp_trunc = 0;

    task automatic add_packet(input int p, input logic [DW-1:0] base, input int len);
        for (int i = 0; i < len; i++) begin
            pq[p].push_back({(i == len - 1), base + DW'(i)});
        end
    endtask

    // Packet-level model: every requester with pending words competes; the owner
    // sends until its last word or MAX_BURST words, then the pointer moves past it.
    task automatic model_build();
        int p, n, c;
        bit done;
        logic [DW:0] w;
        for (int i = 0; i < NP; i++) mq[i] = pq[i];
        exp_q.delete();
        exp_grants.delete();
        while (1) begin
            p = -1;
            for (int off = 0; off < NP; off++) begin
                c = (model_rr + off) % NP;
                if (p < 0 && mq[c].size() > 0) p = c;
            end
            if (p < 0) break;
            exp_grants.push_back(NP'(1) << p);
`ifdef FIFO_ARB_HEADER_EN
            exp_q.push_back(16'hA000 | (16'(p) << 8));
`endif
            n = 0;
            done = 0;
            while (!done) begin
                w = mq[p].pop_front();
                exp_q.push_back(w[DW-1:0]);
                n++;
                if (w[DW]) done = 1;
                else if (n == MAXB) begin
                    done = 1;
                    if (exp_trunc < 65535) exp_trunc++;
                end else if (mq[p].size() == 0) done = 1;
            end
            model_rr = (p + 1) % NP;
        end
    endtask

    task automatic run_traffic(input int max_cycles, input int gap_pct, input int full_pct,
                               input int full_start, input int full_len, input bit free_rand);
        int cyc;
        bit timed_out, prev_acc, all_empty;
        logic [NP-1:0] acc, prev_grant;
        logic [DW-1:0] prev_word;
        model_build();
        wr_log.delete();
        grant_log.delete();
        prev_acc   = 0;
        prev_word  = '0;
        prev_grant = bus.grant;
        cyc        = 0;
        timed_out  = 0;
        while (1) begin
            for (int i = 0; i < NP; i++) begin
                if (pq[i].size() > 0) begin
                    bus.req_data[i*DW +: DW] = pq[i][0][DW-1:0];
                    bus.req_last[i]          = pq[i][0][DW];
                    bus.req_valid[i]         = !(bus.grant[i] && (int'($urandom_range(99)) < gap_pct));
                end else begin
                    bus.req_data[i*DW +: DW] = '0;
                    bus.req_last[i]          = 1'b0;
                    bus.req_valid[i]         = 1'b0;
                end
            end
            bus.fifo_wr_full = ((cyc >= full_start) && (cyc < full_start + full_len))
                               || (int'($urandom_range(99)) < full_pct);
            bus.fifo_wr_free = free_rand ? SW'($urandom_range(600)) : SW'(512);
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready;
            total++;
            if ((bus.req_ready & ~bus.grant) !== '0) begin
                bad++; $display("FAIL ready_owner: ready=%b grant=%b", bus.req_ready, bus.grant);
            end
            total++;
            if ($onehot0(bus.grant) !== 1'b1) begin
                bad++; $display("FAIL grant_onehot: grant=%b", bus.grant);
            end
            if (bus.fifo_wr_full || bus.fifo_wr_free < SW'(2)) begin
                total++;
                if (bus.req_ready !== '0) begin
                    bad++; $display("FAIL ready_no_space: ready=%b want 0", bus.req_ready);
                end
            end
`ifndef FIFO_ARB_HEADER_EN
            total++;
            if (bus.fifo_wr_en !== prev_acc) begin
                bad++; $display("FAIL wr_en_latency: wr_en=%b want %b", bus.fifo_wr_en, prev_acc);
            end
            if (prev_acc) begin
                total++;
                if (bus.fifo_wr_data !== prev_word) begin
                    bad++; $display("FAIL wr_data: got %h want %h", bus.fifo_wr_data, prev_word);
                end
            end
`endif
            if (bus.fifo_wr_en === 1'b1) wr_log.push_back(bus.fifo_wr_data);
            if (bus.grant !== '0 && prev_grant === '0) grant_log.push_back(bus.grant);
            prev_grant = bus.grant;
            prev_acc   = 0;
            for (int i = 0; i < NP; i++) begin
                if (acc[i] && pq[i].size() > 0) begin
                    prev_word = pq[i][0][DW-1:0];
                    void'(pq[i].pop_front());
                    prev_acc = 1;
                end
            end
            all_empty = 1;
            for (int i = 0; i < NP; i++) if (pq[i].size() > 0) all_empty = 0;
            if (all_empty && bus.grant === '0 && !prev_acc) break;
            cyc++;
            if (cyc >= max_cycles) begin
                timed_out = 1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.req_valid    = '0;
        bus.req_last     = '0;
        bus.fifo_wr_full = 1'b0;
        bus.fifo_wr_free = SW'(512);
        total++;
        if (timed_out) begin
            bad++; $display("FAIL traffic_timeout: cycles=%0d limit=%0d", cyc, max_cycles);
            for (int i = 0; i < NP; i++) pq[i].delete();
        end
        total++;
        if (wr_log.size() !== exp_q.size()) begin
            bad++; $display("FAIL stream_len: got %0d want %0d", wr_log.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < wr_log.size()) begin
                total++;
                if (wr_log[k] !== exp_q[k]) begin
                    bad++; $display("FAIL stream_word[%0d]: got %h want %h", k, wr_log[k], exp_q[k]);
                end
            end
        end
        total++;
        if (grant_log.size() !== exp_grants.size()) begin
            bad++; $display("FAIL grant_seq_len: got %0d want %0d", grant_log.size(), exp_grants.size());
        end
        for (int k = 0; k < exp_grants.size(); k++) begin
            if (k < grant_log.size()) begin
                total++;
                if (grant_log[k] !== exp_grants[k]) begin
                    bad++; $display("FAIL grant_seq[%0d]: got %b want %b", k, grant_log[k], exp_grants[k]);
                end
            end
        end
        total++;
        if (bus.trunc_count !== 16'(exp_trunc)) begin
            bad++; $display("FAIL trunc_count: got %0d want %0d", bus.trunc_count, exp_trunc);
        end
        total++;
        if (bus.grant !== '0) begin
            bad++; $display("FAIL grant_idle_after: got %b want 0", bus.grant);
        end
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        bus.req_valid    = '0;
        bus.req_data     = '0;
        bus.req_last     = '0;
        bus.fifo_wr_full = 1'b0;
        bus.fifo_wr_free = SW'(512);
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (bus.req_ready !== '0) begin bad++; $display("FAIL rst_ready: got %b want 0", bus.req_ready); end
        total++; if (bus.fifo_wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en: got %b want 0", bus.fifo_wr_en); end
        total++; if (bus.fifo_wr_data !== '0) begin bad++; $display("FAIL rst_wr_data: got %h want 0", bus.fifo_wr_data); end
        total++; if (bus.grant !== '0) begin bad++; $display("FAIL rst_grant: got %b want 0", bus.grant); end
        total++; if (bus.trunc_count !== '0) begin bad++; $display("FAIL rst_trunc: got %h want 0", bus.trunc_count); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        model_rr  = 0;
        exp_trunc = 0;
    endtask

    task automatic test_single_packet();
        add_packet(0, 16'h1000, 4);
        run_traffic(100, 0, 0, -1, 0, 0);
    endtask

    task automatic test_alternate();
        for (int k = 0; k < 3; k++) begin
            add_packet(0, 16'h1100 + 16'(k * 16), 2);
            add_packet(1, 16'h2100 + 16'(k * 16), 2);
        end
        run_traffic(200, 0, 0, -1, 0, 0);
    endtask

    task automatic test_min_free();
        int k;
        bus.fifo_wr_full         = 1'b0;
        bus.fifo_wr_free         = SW'(63);
        bus.req_data[DW +: DW]   = 16'h2222;
        bus.req_last             = 2'b10;
        bus.req_valid            = 2'b10;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (bus.grant !== '0) begin bad++; $display("FAIL grant_low_free: got %b want 00", bus.grant); end
            @(posedge clk); #1;
        end
        bus.fifo_wr_free = SW'(64);
        k = 0;
        @(negedge clk);
        while (k < 1 && bus.grant !== 2'b10) begin
            @(posedge clk); #1; @(negedge clk); k++;
        end
        total++;
        if (bus.grant !== 2'b10) begin bad++; $display("FAIL grant_after_free: got %b want 10", bus.grant); end
        k = 0;
        while (k < 4 && bus.req_ready !== 2'b10) begin
            @(posedge clk); #1; @(negedge clk); k++;
        end
        total++;
        if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL ready_after_grant: got %b want 10", bus.req_ready); end
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.req_last  = '0;
        @(negedge clk);
        total++;
        if (bus.fifo_wr_en !== 1'b1 || bus.fifo_wr_data !== 16'h2222) begin
            bad++; $display("FAIL min_free_word: wr_en=%b data=%h want 1/2222", bus.fifo_wr_en, bus.fifo_wr_data);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (bus.grant !== '0) begin bad++; $display("FAIL min_free_release: got %b want 00", bus.grant); end
        @(posedge clk); #1;
        bus.fifo_wr_free = SW'(512);
        model_rr = 0;
    endtask

    task automatic test_truncation();
        add_packet(0, 16'h4000, 300);
        add_packet(1, 16'h7000, 3);
        run_traffic(1500, 0, 0, -1, 0, 0);
    endtask

    task automatic test_full_stall();
        add_packet(0, 16'h3000, 20);
        run_traffic(200, 0, 0, 5, 5, 0);
    endtask

    task automatic test_random();
        int n, words;
        for (int r = 0; r < 3; r++) begin
            words = 0;
            for (int p = 0; p < NP; p++) begin
                n = int'($urandom_range(5, 2));
                for (int k = 0; k < n; k++) begin
                    int len;
                    len = int'($urandom_range(40, 1));
                    add_packet(p, 16'($urandom), len);
                    words += len;
                end
            end
            run_traffic(words * 12 + 200, 30, 10, -1, 0, 1);
        end
    endtask

`ifdef FIFO_ARB_HEADER_EN
    task automatic test_header();
        logic [DW-1:0] first;
        add_packet(1, 16'hBEEF, 1);
        run_traffic(100, 0, 0, -1, 0, 0);
        first = (wr_log.size() > 0) ? wr_log[0] : 'x;
        total++;
        if (first !== 16'hA100) begin bad++; $display("FAIL header_word: got %h want a100", first); end
    endtask
`endif

    task automatic test_reset_mid_burst();
        bus.fifo_wr_free = SW'(512);
        bus.fifo_wr_full = 1'b0;
        bus.req_last     = '0;
        bus.req_valid    = 2'b01;
        for (int i = 0; i < 8; i++) begin
            bus.req_data[0 +: DW] = 16'h5000 + 16'(i);
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++;
        if (bus.grant !== 2'b01 || bus.fifo_wr_en !== 1'b1) begin
            bad++; $display("FAIL pre_reset_burst: grant=%b wr_en=%b want 01/1", bus.grant, bus.fifo_wr_en);
        end
        #2;
        reset = 1'b1;
        #1;
        total++; if (bus.grant !== '0) begin bad++; $display("FAIL mid_rst_grant: got %b want 0", bus.grant); end
        total++; if (bus.req_ready !== '0) begin bad++; $display("FAIL mid_rst_ready: got %b want 0", bus.req_ready); end
        total++; if (bus.fifo_wr_en !== 1'b0) begin bad++; $display("FAIL mid_rst_wr_en: got %b want 0", bus.fifo_wr_en); end
        total++; if (bus.fifo_wr_data !== '0) begin bad++; $display("FAIL mid_rst_data: got %h want 0", bus.fifo_wr_data); end
        total++; if (bus.trunc_count !== '0) begin bad++; $display("FAIL mid_rst_trunc: got %h want 0", bus.trunc_count); end
        bus.req_valid = '0;
        @(posedge clk); #1;
        reset     = 1'b0;
        model_rr  = 0;
        exp_trunc = 0;
        @(posedge clk); #1;
        add_packet(1, 16'h6000, 2);
        run_traffic(100, 0, 0, -1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_alternate();
        test_min_free();
        test_truncation();
        test_full_stall();
        test_random();
`ifdef FIFO_ARB_HEADER_EN
        test_header();
`endif
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

endmodule
